// File: rtl/alu_pkg.sv
// alu_pkg: opcode and scheduler state definitions shared by alu_sched and its ALU
package alu_pkg;

    typedef enum logic [3:0] {
        ADD = 4'd0,
        SUB = 4'd1,
        NOT = 4'd2,
        AND = 4'd3,
        OR  = 4'd4,
        XOR = 4'd5,
        RSH = 4'd6,
        LSH = 4'd7,
        GT  = 4'd8,
        EQ  = 4'd9,
        LT  = 4'd10
    } alu_op_t;

    localparam logic [3:0] OP_LAST = 4'd10;

    typedef logic [1:0] sched_state_t;
    localparam sched_state_t IDLE  = 2'd0;
    localparam sched_state_t EXEC  = 2'd1;
    localparam sched_state_t SHIFT = 2'd2;
    localparam sched_state_t RESP  = 2'd3;

    function automatic logic is_shift(input logic [3:0] op);
        return op == RSH || op == LSH;
    endfunction

endpackage

// File: rtl/alu.sv
// alu: combinational ALU; RSH/LSH move by exactly one bit, illegal opcodes give zero
//  op  in  4          opcode (alu_op_t encoding)
//  a   in  bit_width  operand A
//  b   in  bit_width  operand B
//  y   out bit_width  result; compares are unsigned and give all-ones/all-zeros
module alu
    import alu_pkg::*;
#(
    parameter int bit_width = 32
) (
    input  logic [3:0]           op,
    input  logic [bit_width-1:0] a,
    input  logic [bit_width-1:0] b,
    output logic [bit_width-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            ADD:     y = a + b;
            SUB:     y = a - b;
            NOT:     y = ~a;
            AND:     y = a & b;
            OR:      y = a | b;
            XOR:     y = a ^ b;
            RSH:     y = a >> 1;
            LSH:     y = a << 1;
            GT:      y = {bit_width{a > b}};
            EQ:      y = {bit_width{a == b}};
            LT:      y = {bit_width{a < b}};
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first requester at or after ptr, wrapping modulo N
//  req    in  N           request vector
//  ptr    in  $clog2(N)   highest-priority index
//  grant  out N           one-hot grant, zero when no request
//  idx    out $clog2(N)   encoded grant index, zero when no request
//  any    out 1           at least one request present
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    localparam int IW = $clog2(N);

    int j;

    // Scan from the farthest offset down so the nearest requester to ptr wins.
    always_comb begin
        grant = '0;
        idx = '0;
        j = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
                grant = N'(1) << j;
                idx = IW'(j);
            end
        end
        any = |req;
    end

endmodule

// File: rtl/alu_sched.sv
// alu_sched: round-robin scheduler sharing one ALU among NUM_REQ requesters, one transaction in flight
//  clk        in   1                  clock, rising edge
//  rst_n      in   1                  asynchronous active-low reset
//  req_valid  in   NUM_REQ            per-requester request valid
//  req_ready  out  NUM_REQ            one-hot grant, only in IDLE
//  req_op     in   NUM_REQ*4          opcode per requester
//  req_a      in   NUM_REQ*BIT_WIDTH  operand A per requester
//  req_b      in   NUM_REQ*BIT_WIDTH  operand B per requester; shift amount for RSH/LSH
//  rsp_valid  out  1                  result valid
//  rsp_ready  in   1                  consumer accepts result
//  rsp_id     out  $clog2(NUM_REQ)    requester that issued the result
//  rsp_data   out  BIT_WIDTH          result
//  busy       out  1                  not IDLE
// Optional (macro ALU_SCHED_FLAGS_EN): rsp_zero, rsp_neg, rsp_err registered alongside rsp_data.
module alu_sched
    import alu_pkg::*;
#(
    parameter int BIT_WIDTH = 32,
    parameter int NUM_REQ   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*4-1:0]         req_op,
    input  logic [NUM_REQ*BIT_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*BIT_WIDTH-1:0] req_b,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
    output logic [BIT_WIDTH-1:0]         rsp_data,
`ifdef ALU_SCHED_FLAGS_EN
    output logic                         rsp_zero,
    output logic                         rsp_neg,
    output logic                         rsp_err,
`endif
    output logic                         busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int SW = $clog2(BIT_WIDTH);

    sched_state_t         state;
    logic [IW-1:0]        ptr;
    logic [IW-1:0]        gidx;
    logic [NUM_REQ-1:0]   grant;
    logic                 any;
    logic                 accept;
    logic [3:0]           g_op;
    logic [BIT_WIDTH-1:0] g_a;
    logic [BIT_WIDTH-1:0] g_b;
    logic [3:0]           op_r;
    logic [BIT_WIDTH-1:0] a_r;
    logic [BIT_WIDTH-1:0] b_r;
    logic [SW-1:0]        cnt;
    logic [BIT_WIDTH-1:0] alu_y;
    logic                 legal;
    logic                 load;
    logic [BIT_WIDTH-1:0] res;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (gidx),
        .any   (any)
    );

    alu #(.bit_width(BIT_WIDTH)) u_alu (
        .op (op_r),
        .a  (a_r),
        .b  (b_r),
        .y  (alu_y)
    );

    assign g_op      = req_op[4*int'(gidx) +: 4];
    assign g_a       = req_a[BIT_WIDTH*int'(gidx) +: BIT_WIDTH];
    assign g_b       = req_b[BIT_WIDTH*int'(gidx) +: BIT_WIDTH];
    assign accept    = state == IDLE && any;
    assign req_ready = state == IDLE ? grant : '0;
    assign rsp_valid = state == RESP;
    assign busy      = state != IDLE;
    assign legal     = op_r <= OP_LAST;

    // Zero-distance shifts come through EXEC and must return A untouched,
    // since the ALU itself always moves by one bit.
    assign load = state == EXEC || (state == SHIFT && cnt == SW'(1));
    assign res  = state == SHIFT ? alu_y : !legal ? '0 : is_shift(op_r) ? a_r : alu_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr    <= '0;
            op_r   <= '0;
            a_r    <= '0;
            b_r    <= '0;
            cnt    <= '0;
            rsp_id <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_r   <= g_op;
                    a_r    <= g_a;
                    b_r    <= g_b;
                    cnt    <= g_b[SW-1:0];
                    rsp_id <= gidx;
                    ptr    <= gidx == IW'(NUM_REQ - 1) ? '0 : gidx + IW'(1);
                    state  <= is_shift(g_op) && g_b[SW-1:0] != '0 ? SHIFT : EXEC;
                end
                EXEC: state <= RESP;
                SHIFT: begin
                    a_r   <= alu_y;
                    cnt   <= cnt - SW'(1);
                    state <= cnt == SW'(1) ? RESP : SHIFT;
                end
                default: state <= rsp_ready ? IDLE : RESP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data <= '0;
`ifdef ALU_SCHED_FLAGS_EN
            rsp_zero <= 1'b0;
            rsp_neg  <= 1'b0;
            rsp_err  <= 1'b0;
`endif
        end else if (load) begin
            rsp_data <= res;
`ifdef ALU_SCHED_FLAGS_EN
            rsp_zero <= res == '0;
            rsp_neg  <= res[BIT_WIDTH-1];
            rsp_err  <= state == EXEC && !legal;
`endif
        end
    end

endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: scoreboard bench for alu_sched with a behavioural reference model
module tb_alu_sched;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   v = '0;
    logic [3:0]   ops [4];
    logic [31:0]  as_ [4];
    logic [31:0]  bs_ [4];
    logic [15:0]  req_op;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [3:0]   req_ready;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_data;
    logic         busy;
`ifdef ALU_SCHED_FLAGS_EN
    logic         rsp_zero;
    logic         rsp_neg;
    logic         rsp_err;
`endif

    always #5 clk = ~clk;

    always_comb begin
        req_op = '0;
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < 4; i++) begin
            req_op[4*i +: 4] = ops[i];
            req_a[32*i +: 32] = as_[i];
            req_b[32*i +: 32] = bs_[i];
        end
    end

    alu_sched #(.BIT_WIDTH(32), .NUM_REQ(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (v),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
`ifdef ALU_SCHED_FLAGS_EN
        .rsp_zero  (rsp_zero),
        .rsp_neg   (rsp_neg),
        .rsp_err   (rsp_err),
`endif
        .busy      (busy)
    );

    function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = int'(b % 32);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return ~a;
            4'd3:    return a & b;
            4'd4:    return a | b;
            4'd5:    return a ^ b;
            4'd6:    return a >> n;
            4'd7:    return a << n;
            4'd8:    return a > b ? 32'hFFFF_FFFF : 32'h0;
            4'd9:    return a == b ? 32'hFFFF_FFFF : 32'h0;
            4'd10:   return a < b ? 32'hFFFF_FFFF : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b);
        return ((op == 4'd6 || op == 4'd7) && (b % 32) != 0) ? 1 + int'(b % 32) : 2;
    endfunction

    typedef struct {
        logic [1:0]  id;
        logic [31:0] data;
        int          due;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   ptr_m = 0;
    int   errors = 0;
    int   checks = 0;
    int   tmo_n = 0;
    int   tmo_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic       idle_m;
        logic [3:0] exp_g;
        int         gi;
        int         j;
        exp_t       e;
        if (!rst_n) begin
            chk("rst_valid", {31'b0, rsp_valid}, 32'd0);
            chk("rst_busy", {31'b0, busy}, 32'd0);
            chk("rst_ready", {28'b0, req_ready}, 32'd0);
            chk("rst_data", rsp_data, 32'd0);
            chk("rst_id", {30'b0, rsp_id}, 32'd0);
            q.delete();
            ptr_m = 0;
        end else begin
            chk("timeout", tmo_n, tmo_seen);
            tmo_seen = tmo_n;
            idle_m = q.size() == 0;
            chk("busy", {31'b0, busy}, {31'b0, !idle_m});
            exp_g = '0;
            gi = -1;
            if (idle_m) begin
                for (int k = 3; k >= 0; k--) begin
                    j = (ptr_m + k) % 4;
                    if (v[j]) gi = j;
                end
            end
            if (gi >= 0) exp_g[gi] = 1'b1;
            chk("grant", {28'b0, req_ready}, {28'b0, exp_g});
            chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, q.size() != 0 && cyc >= q[0].due});
            if (rsp_valid && q.size() != 0) begin
                e = q[0];
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_id", {30'b0, rsp_id}, {30'b0, e.id});
`ifdef ALU_SCHED_FLAGS_EN
                chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
                chk("rsp_zero", {31'b0, rsp_zero}, {31'b0, e.data == 0});
                chk("rsp_neg", {31'b0, rsp_neg}, {31'b0, e.data[31]});
`endif
                if (rsp_ready) void'(q.pop_front());
            end
            if (gi >= 0) begin
                e.id = 2'(gi);
                e.data = ref_res(ops[gi], as_[gi], bs_[gi]);
                e.due = cyc + ref_lat(ops[gi], bs_[gi]);
                e.err = ops[gi] > 4'd10;
                q.push_back(e);
                ptr_m = (gi + 1) % 4;
            end
        end
    end

    task automatic new_txn(input int i);
        ops[i] = 4'($urandom_range(0, 15));
        as_[i] = $urandom;
        bs_[i] = ($urandom % 3 == 0) ? $urandom : $urandom_range(0, 9);
    endtask

    task automatic issue(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bit ok;
        ok = 0;
        @(posedge clk);
        #1;
        ops[i] = op;
        as_[i] = a;
        bs_[i] = b;
        v[i] = 1'b1;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            ok = req_ready[i];
        end
        if (!ok) tmo_n++;
        @(posedge clk);
        #1;
        v[i] = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            ok = !busy;
        end
        if (!ok) tmo_n++;
    endtask

    initial begin
        logic [3:0] g;
        int grants;
        for (int i = 0; i < 4; i++) begin
            ops[i] = '0;
            as_[i] = '0;
            bs_[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        issue(1, 4'd0, 32'hFFFF_FFFF, 32'd2);
        wait_idle();
        issue(1, 4'd1, 32'd5, 32'd7);
        wait_idle();
        issue(0, 4'd7, 32'h1, 32'd31);
        wait_idle();
        issue(2, 4'd6, 32'hF0, 32'd36);
        wait_idle();
        issue(3, 4'd7, 32'h1234_5678, 32'd32);
        wait_idle();

        rsp_ready = 1'b0;
        issue(3, 4'd5, 32'hA5A5_0F0F, 32'h0FF0_1234);
        repeat (10) @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait_idle();
        issue(0, 4'd13, 32'd5, 32'd5);
        wait_idle();
        issue(2, 4'd8, 32'd3, 32'd2);
        wait_idle();

        rsp_ready = 1'b0;
        issue(2, 4'd0, 32'd10, 32'd20);
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;

        for (int i = 0; i < 4; i++) new_txn(i);
        v = 4'hF;
        grants = 0;
        for (int c = 0; c < 400 && grants < 5; c++) begin
            @(negedge clk);
            g = req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) if (g[i]) begin
                new_txn(i);
                grants++;
            end
        end
        if (grants < 5) tmo_n++;
        v = '0;
        wait_idle();

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            g = req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (g[i]) begin
                    v[i] = $urandom % 2 == 0;
                    new_txn(i);
                end else if (!v[i] && $urandom % 4 == 0) begin
                    new_txn(i);
                    v[i] = 1'b1;
                end else if (v[i] && $urandom % 40 == 0) begin
                    v[i] = 1'b0;
                end
            end
            rsp_ready = $urandom % 4 != 0;
        end
        v = '0;
        rsp_ready = 1'b1;
        wait_idle();
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
